// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch queue feeding IF/ID.
// One outstanding imem read; redirects flush all but the delay-slot head.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wpcir,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        inst_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc4_mem  [DEPTH];

  logic        pop;
  logic        ack;
  logic        push;
  logic        keep;
  logic        room;
  logic [31:0] pc_sel;

  assign inst_valid = (cnt_q != '0);
  assign inst       = inst_valid ? inst_mem[rd_q] : '0;
  assign pc4        = inst_valid ? pc4_mem[rd_q] : '0;
  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = addr_q;

  always_comb begin
    pop    = inst_valid & wpcir;
    ack    = imem_ack & (state_q != IDLE);
    push   = ack & (state_q == WAIT) & ~redirect;
    keep   = inst_valid & ~wpcir;
    pc_sel = redirect ? redirect_pc : pc_q;
    rd_d   = rd_q + PW'(pop);
    if (redirect) begin
      // only an unconsumed head (delay slot) survives
      wr_d  = rd_d + PW'(keep);
      cnt_d = CW'(keep);
    end else begin
      wr_d  = wr_q + PW'(push);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    room = (cnt_d < CW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_sel;
    if (state_q == IDLE || ack) begin
      if (room) begin
        state_d = WAIT;
        addr_d  = pc_sel;
        pc_d    = pc_sel + 32'd4;
      end else begin
        state_d = IDLE;
      end
    end else if (redirect) begin
      state_d = DROP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_q] <= imem_rdata;
      pc4_mem[wr_q]  <= addr_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a queue-level
// reference model compared on every cycle.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wpcir = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        inst_valid;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .wpcir(wpcir),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .pc4(pc4), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  int          wcnt;
  int          lat;
  bit          spur;
  int          tests;
  int          fails;
  int          cyc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [31:0] ei, ep;
    bit ev;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].inst : 32'h0;
    ep = ev ? mq[0].pc4 : 32'h0;
    tests++;
    if (imem_req !== m_out || (m_out && imem_addr !== m_addr) ||
        inst_valid !== ev || inst !== ei || pc4 !== ep) begin
      fails++;
      $display("FAIL cycle%0d: req=%b addr=%h v=%b inst=%h pc4=%h expected req=%b addr=%h v=%b inst=%h pc4=%h",
               cyc, imem_req, imem_addr, inst_valid, inst, pc4,
               m_out, m_addr, ev, ei, ep);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = 0;
    m_drop = 0;
    m_addr = RPC;
    m_pc = RPC;
    wcnt = 0;
  endtask

  task automatic model_next(input logic wp, input logic rd,
                            input logic [31:0] rpc);
    bit v, ackd;
    ent_t e;
    v = (mq.size() > 0);
    ackd = m_out && imem_ack;
    if (rd) begin
      if (v && !wp) begin
        e = mq[0];
        mq.delete();
        mq.push_back(e);
      end else begin
        mq.delete();
      end
      m_pc = rpc;
    end else begin
      if (v && wp) void'(mq.pop_front());
      if (ackd && !m_drop) begin
        e.inst = imem_rdata;
        e.pc4 = m_addr + 32'd4;
        mq.push_back(e);
      end
    end
    if (!m_out || ackd) begin
      if (mq.size() < DEPTH) begin
        m_out = 1;
        m_drop = 0;
        m_addr = m_pc;
        m_pc = m_pc + 32'd4;
        wcnt = 0;
      end else begin
        m_out = 0;
      end
    end else begin
      if (rd) m_drop = 1;
      wcnt++;
    end
  endtask

  task automatic step(input logic wp, input logic rd,
                      input logic [31:0] rpc);
    check_cycle();
    wpcir = wp;
    redirect = rd;
    redirect_pc = rpc;
    imem_ack = (m_out && wcnt >= lat) || spur;
    imem_rdata = ~m_addr;
    model_next(wp, rd, rpc);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wpcir = 0;
    redirect = 0;
    redirect_pc = '0;
    imem_ack = 0;
    spur = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    lat = 0;
    spur = 0;
    model_reset();
    @(negedge clk);

    // sequential stream, ack one cycle after each request
    do_reset();
    lat = 1;
    step(1, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RPC);
    repeat (12) step(1, 0, 0);

    // decode stalled: queue fills to DEPTH and fetching stops
    do_reset();
    lat = 0;
    repeat (8) step(0, 0, 0);
    chk("full_req", {31'b0, imem_req}, 32'h0);
    chk("full_pc4", pc4, 32'h4);
    chk("full_inst", inst, 32'hFFFF_FFFF);
    spur = 1;
    repeat (2) step(0, 0, 0);
    spur = 0;
    chk("spur_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 12; i++) step(i % 3 != 0, 0, 0);

    // redirect while request to 0x10 is outstanding
    do_reset();
    lat = 0;
    repeat (5) step(1, 0, 0);
    chk("d_addr10", imem_addr, 32'h10);
    lat = 3;
    step(0, 1, 32'h400);
    for (int i = 0; i < 10 && !(m_out && !m_drop); i++) step(0, 0, 0);
    chk("d_addr400", imem_addr, 32'h400);
    chk("d_head", pc4, 32'h10);
    step(1, 0, 0);
    for (int i = 0; i < 10 && mq.size() == 0; i++) step(1, 0, 0);
    chk("d_pc404", pc4, 32'h404);
    chk("d_inst", inst, 32'hFFFF_FBFF);

    // queue 0x20/0x24/0x28, redirect with delay slot consumed
    do_reset();
    lat = 0;
    step(0, 1, 32'h20);
    repeat (3) step(0, 0, 0);
    chk("e_head", pc4, 32'h24);
    step(1, 1, 32'h100);
    chk("e_valid", {31'b0, inst_valid}, 32'h0);
    chk("e_addr", imem_addr, 32'h100);
    step(0, 0, 0);
    chk("e_pc104", pc4, 32'h104);

    // address wrap, then reset mid-request
    do_reset();
    lat = 0;
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("w_addr", imem_addr, 32'h0);
    chk("w_pc4", pc4, 32'h0);
    chk("w_inst", inst, 32'h3);
    lat = 50;
    step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {31'b0, imem_req}, 32'h0);
    chk("ar_addr", imem_addr, RPC);
    chk("ar_valid", {31'b0, inst_valid}, 32'h0);
    chk("ar_pc4", pc4, 32'h0);
    imem_ack = 1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // mixed latencies, stalls and redirects
    for (int i = 0; i < 60; i++) begin
      lat = i % 3;
      step(i % 2 == 0, i % 7 == 3, 32'h300 + 32'(i * 16));
    end
    check_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
